// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus sequencer.
package hpi_pkg;

   localparam int unsigned HPI_CNT_W = 4;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      HOLD    = 3'd3,
      RECOVER = 3'd4
   } hpi_state_t;

endpackage

// File: rtl/hpi_sync2.sv
// Two-flop synchronizer for the asynchronous HPI interrupt pin.
module hpi_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/hpi_bus_sequencer.sv
// Avalon-MM slave sequencing CPU accesses onto the CY7C67200 HPI pins.
// Optional HPI_IRQ_SYNC_EN: synchronizes otg_int onto irq (otherwise irq is tied 0).
module hpi_bus_sequencer
   import hpi_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES   = 1,
   parameter int unsigned STROBE_CYCLES  = 3,
   parameter int unsigned RECOVER_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [15:0] avs_writedata,
   output logic [15:0] avs_readdata,
   output logic        avs_waitrequest,
   output logic [1:0]  otg_addr,
   output logic        otg_cs_n,
   output logic        otg_rd_n,
   output logic        otg_wr_n,
   output logic [15:0] otg_data_out,
   output logic        otg_data_oe,
   input  logic [15:0] otg_data_in,
   input  logic        otg_int,
   output logic        irq
);

   hpi_state_t           state;
   logic [HPI_CNT_W-1:0] cnt;
   logic                 is_write;

   // otg_addr and otg_data_out double as the latched request, so master
   // changes after the request is taken never reach the pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         cnt             <= '0;
         is_write        <= 1'b0;
         otg_addr        <= '0;
         otg_cs_n        <= 1'b1;
         otg_rd_n        <= 1'b1;
         otg_wr_n        <= 1'b1;
         otg_data_out    <= '0;
         otg_data_oe     <= 1'b0;
         avs_readdata    <= '0;
         avs_waitrequest <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (avs_read || avs_write) begin
                  is_write    <= avs_write;
                  otg_addr    <= avs_address;
                  otg_cs_n    <= 1'b0;
                  otg_data_oe <= avs_write;
                  if (avs_write) otg_data_out <= avs_writedata;
                  cnt         <= HPI_CNT_W'(SETUP_CYCLES - 1);
                  state       <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  otg_rd_n <= is_write;
                  otg_wr_n <= !is_write;
                  cnt      <= HPI_CNT_W'(STROBE_CYCLES - 1);
                  state    <= STROBE;
               end else begin
                  cnt <= cnt - HPI_CNT_W'(1);
               end
            end
            STROBE: begin
               if (cnt == '0) begin
                  otg_rd_n        <= 1'b1;
                  otg_wr_n        <= 1'b1;
                  avs_waitrequest <= 1'b0;
                  if (!is_write) avs_readdata <= otg_data_in;
                  state           <= HOLD;
               end else begin
                  cnt <= cnt - HPI_CNT_W'(1);
               end
            end
            HOLD: begin
               avs_waitrequest <= 1'b1;
               otg_cs_n        <= 1'b1;
               otg_data_oe     <= 1'b0;
               cnt             <= HPI_CNT_W'(RECOVER_CYCLES - 1);
               state           <= RECOVER;
            end
            RECOVER: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - HPI_CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HPI_IRQ_SYNC_EN
   hpi_sync2 u_irq_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (otg_int),
      .q       (irq)
   );
`else
   logic unused_otg_int;
   assign unused_otg_int = otg_int;
   assign irq            = 1'b0;
`endif

endmodule
